// File: rtl/mimc_round_sequencer.sv
// MiMC-7 round sequencer over the BN254 scalar field: walks NUM_ROUNDS rounds of
// (x + k + c)^7 using an external fixed-latency modular multiplier and a round-constant ROM.
module mimc_round_sequencer #(
  parameter int N_BITS     = 254,
  parameter int NUM_ROUNDS = 91,
  parameter int MUL_LAT    = 16,
  parameter int ADDR_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] in_x,
  input  logic [N_BITS-1:0] in_k,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] out_h,
  output logic [ADDR_W-1:0] rc_addr,
  input  logic [N_BITS-1:0] rc_data,
  output logic [N_BITS-1:0] mul_a,
  output logic [N_BITS-1:0] mul_b,
  input  logic [N_BITS-1:0] mul_p,
  output logic [3:0]        o_dbg_state
);

  localparam logic [N_BITS-1:0] P =
    N_BITS'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001);
  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0]  PHASE_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [ADDR_W-1:0] ROUND_LAST = ADDR_W'(NUM_ROUNDS - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_ADD   = 4'd2,
    S_SQ    = 4'd3,
    S_CUBE  = 4'd4,
    S_SIX   = 4'd5,
    S_SEVEN = 4'd6,
    S_FINAL = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [N_BITS-1:0]   r_x;
  logic [N_BITS-1:0]   r_k;
  logic [N_BITS-1:0]   r_t;
  logic [N_BITS-1:0]   r_out_h;
  logic [N_BITS-1:0]   r_mul_a;
  logic [N_BITS-1:0]   r_mul_b;
  logic [ADDR_W-1:0]   r_round;
  logic [ADDR_W-1:0]   r_rc_addr;
  logic [CNT_W-1:0]    r_phase_cnt;
  logic [N_BITS-1:0]   w_xk;
  logic [N_BITS-1:0]   w_t;
  logic                w_phase_last;
  logic                w_last_round;

  // Inputs are always reduced, so one conditional subtraction keeps the sum below p.
  function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a,
                                                 input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) begin
      s = s - {1'b0, P};
    end
    return s[N_BITS-1:0];
  endfunction

  assign w_xk         = mod_add(r_x, r_k);
  assign w_t          = mod_add(w_xk, rc_data);
  assign w_phase_last = (r_phase_cnt == PHASE_LAST);
  assign w_last_round = (r_round == ROUND_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next_state = S_FETCH;
      S_FETCH: w_next_state = S_ADD;
      S_ADD:   w_next_state = S_SQ;
      S_SQ:    if (w_phase_last) w_next_state = S_CUBE;
      S_CUBE:  if (w_phase_last) w_next_state = S_SIX;
      S_SIX:   if (w_phase_last) w_next_state = S_SEVEN;
      S_SEVEN: if (w_phase_last) w_next_state = w_last_round ? S_FINAL : S_FETCH;
      S_FINAL: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  // Operand registers feed the multiplier directly; each phase's product becomes
  // the next phase's operand on the edge that closes the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_k         <= '0;
      r_t         <= '0;
      r_out_h     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_round     <= '0;
      r_rc_addr   <= '0;
      r_phase_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_phase_cnt <= '0;
          if (start) begin
            r_x       <= in_x;
            r_k       <= in_k;
            r_round   <= '0;
            r_rc_addr <= '0;
          end
        end
        S_ADD: begin
          r_t         <= w_t;
          r_mul_a     <= w_t;
          r_mul_b     <= w_t;
          r_phase_cnt <= '0;
        end
        S_SQ, S_CUBE, S_SIX, S_SEVEN: begin
          if (!w_phase_last) begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end else begin
            r_phase_cnt <= '0;
            if (r_state == S_SQ) begin
              r_mul_a <= mul_p;
              r_mul_b <= r_t;
            end else if (r_state == S_CUBE) begin
              r_mul_a <= mul_p;
              r_mul_b <= mul_p;
            end else if (r_state == S_SIX) begin
              r_mul_a <= mul_p;
              r_mul_b <= r_t;
            end else begin
              r_x <= mul_p;
              if (!w_last_round) begin
                r_round   <= r_round + 1'b1;
                r_rc_addr <= r_round + 1'b1;
              end
            end
          end
        end
        S_FINAL: r_out_h <= w_xk;
        default: ;
      endcase
    end
  end

  assign out_h   = r_out_h;
  assign rc_addr = r_rc_addr;
  assign mul_a   = r_mul_a;
  assign mul_b   = r_mul_b;

endmodule

// File: tb/tb_mimc_round_sequencer.sv
// Bench for mimc_round_sequencer: a 91-round instance (a_) and a 1-round instance (b_),
// each with its own ROM and a pipelined modular-multiplier model.
module tb_mimc_round_sequencer;
  localparam int N    = 254;
  localparam int ML   = 16;
  localparam int AW   = 7;
  localparam int NR_A = 91;
  localparam int NR_B = 1;
  localparam logic [255:0] P256 =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [N-1:0] P = N'(P256);
  localparam logic [3:0] FETCH_ENC = 4'd1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_start, a_busy, a_done, b_start, b_busy, b_done;
  logic [N-1:0]  a_x, a_k, a_out_h, a_rc_data, a_mul_a, a_mul_b, a_mul_p;
  logic [N-1:0]  b_x, b_k, b_out_h, b_rc_data, b_mul_a, b_mul_b, b_mul_p;
  logic [AW-1:0] a_rc_addr, b_rc_addr;
  logic [3:0]    a_dbg, b_dbg;

  int total_checks = 0;
  int passed = 0;
  int failed = 0;

  mimc_round_sequencer #(.N_BITS(N), .NUM_ROUNDS(NR_A), .MUL_LAT(ML), .ADDR_W(AW)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .in_x(a_x), .in_k(a_k),
    .busy(a_busy), .done(a_done), .out_h(a_out_h), .rc_addr(a_rc_addr),
    .rc_data(a_rc_data), .mul_a(a_mul_a), .mul_b(a_mul_b), .mul_p(a_mul_p),
    .o_dbg_state(a_dbg));

  mimc_round_sequencer #(.N_BITS(N), .NUM_ROUNDS(NR_B), .MUL_LAT(ML), .ADDR_W(AW)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .in_x(b_x), .in_k(b_k),
    .busy(b_busy), .done(b_done), .out_h(b_out_h), .rc_addr(b_rc_addr),
    .rc_data(b_rc_data), .mul_a(b_mul_a), .mul_b(b_mul_b), .mul_p(b_mul_p),
    .o_dbg_state(b_dbg));

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] w;
    w = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    return N'(w % {{N{1'b0}}, P});
  endfunction

  // ROMs answer one cycle after the address; products appear MUL_LAT edges after operands.
  logic [N-1:0] rom_a [128];
  logic [N-1:0] rom_b [128];
  logic [N-1:0] a_pipe [ML-1];
  logic [N-1:0] b_pipe [ML-1];

  always @(posedge clk) begin
    a_rc_data <= rom_a[a_rc_addr];
    b_rc_data <= rom_b[b_rc_addr];
    a_pipe[0] <= mulmod(a_mul_a, a_mul_b);
    b_pipe[0] <= mulmod(b_mul_a, b_mul_b);
    for (int i = 1; i < ML - 1; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
  end
  assign a_mul_p = a_pipe[ML-2];
  assign b_mul_p = b_pipe[ML-2];

  function automatic logic [N-1:0] rand_fe();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom())};
    return N'(v % P256);
  endfunction

  function automatic logic [N-1:0] pow7(input logic [N-1:0] t);
    logic [N-1:0] t2, t4, t6;
    t2 = mulmod(t, t);
    t4 = mulmod(t2, t2);
    t6 = mulmod(t4, t2);
    return mulmod(t6, t);
  endfunction

  function automatic logic [N-1:0] ref_hash(input int sel, input logic [N-1:0] x,
                                            input logic [N-1:0] k);
    logic [255:0] s;
    logic [N-1:0] c;
    int nr;
    nr = (sel == 0) ? NR_A : NR_B;
    for (int r = 0; r < nr; r++) begin
      c = (sel == 0) ? rom_a[r] : rom_b[r];
      s = {2'b00, x} + {2'b00, k} + {2'b00, c};
      x = pow7(N'(s % P256));
    end
    s = {2'b00, x} + {2'b00, k};
    return N'(s % P256);
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [N-1:0] x, input logic [N-1:0] k);
    if (sel == 0) begin a_start = s; a_x = x; a_k = k; end
    else begin b_start = s; b_x = x; b_k = k; end
  endtask

  function automatic logic busy_of(input int sel); return (sel == 0) ? a_busy : b_busy; endfunction
  function automatic logic done_of(input int sel); return (sel == 0) ? a_done : b_done; endfunction
  function automatic logic [N-1:0] h_of(input int sel); return (sel == 0) ? a_out_h : b_out_h; endfunction
  function automatic logic [3:0] st_of(input int sel); return (sel == 0) ? a_dbg : b_dbg; endfunction
  function automatic logic [AW-1:0] rc_of(input int sel); return (sel == 0) ? a_rc_addr : b_rc_addr; endfunction

  // Full hash: start sampled at the end of cycle 0, inputs sampled on negedges thereafter.
  task automatic run_hash(input int sel, input logic [N-1:0] x, input logic [N-1:0] k,
                          input logic [N-1:0] exp_h, input string tag);
    int nr, exp_cyc, done_cyc, ndone, fetches, rc_bad;
    logic [N-1:0] h_at_done;
    nr = (sel == 0) ? NR_A : NR_B;
    exp_cyc = nr * (2 + 4 * ML) + 2;
    done_cyc = -1; ndone = 0; fetches = 0; rc_bad = 0; h_at_done = '0;
    @(negedge clk);
    drive(sel, 1'b1, x, k);
    for (int c = 1; c <= exp_cyc + 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        drive(sel, 1'b0, '0, '0);
        check({tag, "_busy"}, 256'(busy_of(sel)), 256'd1);
      end
      if (st_of(sel) == FETCH_ENC) begin
        if (int'(rc_of(sel)) != fetches) rc_bad++;
        fetches++;
      end
      if (done_of(sel)) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c;
          h_at_done = h_of(sel);
        end
      end
    end
    check({tag, "_done_cycle"}, 256'(done_cyc), 256'(exp_cyc));
    check({tag, "_done_pulses"}, 256'(ndone), 256'd1);
    check({tag, "_out_h"}, 256'(h_at_done), 256'(exp_h));
    check({tag, "_out_h_hold"}, 256'(h_of(sel)), 256'(exp_h));
    check({tag, "_fetches"}, 256'(fetches), 256'(nr));
    check({tag, "_rc_addr_seq"}, 256'(rc_bad), 256'd0);
    check({tag, "_idle_busy"}, 256'(busy_of(sel)), 256'd0);
  endtask

  initial begin
    logic [N-1:0] x1, k1, x2, k2, e1, e2, h1, h2, ra, ka;
    int d1, d2, nd;

    rst = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    for (int i = 0; i < 128; i++) begin rom_a[i] = '0; rom_b[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 256'(a_busy), 256'd0);
    check("rst_done", 256'(a_done), 256'd0);
    check("rst_out_h", 256'(a_out_h), 256'd0);
    check("rst_rc_addr", 256'(a_rc_addr), 256'd0);
    check("rst_mul_a", 256'(a_mul_a), 256'd0);
    check("rst_mul_b", 256'(a_mul_b), 256'd0);
    check("rst_b_busy", 256'(b_busy), 256'd0);
    rst = 1'b0;

    run_hash(0, '0, '0, '0, "zero91");
    run_hash(1, N'(2), '0, N'(256'h80), "x2");
    run_hash(1, P - 1'b1, '0, P - 1'b1, "pm1");
    run_hash(1, P - 1'b1, N'(1), N'(1), "wrap");
    rom_b[0] = N'(3);
    run_hash(1, '0, '0, N'(2187), "rc3");

    for (int i = 0; i < 4; i++) begin
      rom_b[0] = rand_fe();
      x1 = rand_fe();
      k1 = rand_fe();
      run_hash(1, x1, k1, ref_hash(1, x1, k1), "rand_b");
    end

    // Start requests while busy and on the done cycle are ignored; the next IDLE cycle accepts.
    rom_b[0] = rand_fe();
    x1 = rand_fe(); k1 = rand_fe(); x2 = rand_fe(); k2 = rand_fe();
    e1 = ref_hash(1, x1, k1);
    e2 = ref_hash(1, x2, k2);
    d1 = -1; d2 = -1; nd = 0; h1 = '0; h2 = '0;
    @(negedge clk);
    drive(1, 1'b1, x1, k1);
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (b_done) begin
        nd++;
        if (d1 < 0) begin d1 = c; h1 = b_out_h; end
        else if (d2 < 0) begin d2 = c; h2 = b_out_h; end
      end
      if (c < 68) drive(1, 1'($urandom_range(0, 1)), rand_fe(), rand_fe());
      else if (c == 68) drive(1, 1'b1, rand_fe(), rand_fe());
      else if (c == 69) drive(1, 1'b1, x2, k2);
      else drive(1, 1'b0, '0, '0);
    end
    check("busy_start_first_done", 256'(d1), 256'd68);
    check("busy_start_first_h", 256'(h1), 256'(e1));
    check("busy_start_second_done", 256'(d2), 256'd137);
    check("busy_start_second_h", 256'(h2), 256'(e2));
    check("busy_start_pulses", 256'(nd), 256'd2);

    for (int i = 0; i < NR_A; i++) rom_a[i] = rand_fe();
    ra = rand_fe();
    ka = rand_fe();
    run_hash(0, ra, ka, ref_hash(0, ra, ka), "rand_a");

    // Abort a hash mid-flight with reset, then rerun both instances.
    @(negedge clk);
    drive(0, 1'b1, rand_fe(), rand_fe());
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b0, '0, '0);
      if (c == 100) rst = 1'b1;
    end
    @(negedge clk);
    check("abort_busy", 256'(a_busy), 256'd0);
    check("abort_out_h", 256'(a_out_h), 256'd0);
    check("abort_rc_addr", 256'(a_rc_addr), 256'd0);
    check("abort_mul_a", 256'(a_mul_a), 256'd0);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (a_done || a_busy) nd++;
    end
    check("abort_quiet", 256'(nd), 256'd0);
    rom_b[0] = '0;
    run_hash(1, N'(2), '0, N'(256'h80), "rerun_x2");
    ra = rand_fe();
    ka = rand_fe();
    run_hash(0, ra, ka, ref_hash(0, ra, ka), "rerun_a");

    $display("%0d/%0d checks passed", passed, total_checks);
    $finish;
  end

endmodule
